// File: rtl/ttwp_pkg.sv
// ttwp_pkg: shared constants and types for the Troy Wide Word Processor front end.
//   IMEM_AW    : instruction memory word-address width
//   INSTR_W    : instruction word width
//   OPCODE_MSB/OPCODE_LSB : opcode field within an instruction (bit 0 is the MSB)
//   HALT_OP    : opcode that stops fetch when the halt feature is built in
//   fetch_entry_t : one prefetch buffer entry {pc, instr}
package ttwp_pkg;

  localparam int IMEM_AW    = 8;
  localparam int INSTR_W    = 32;
  localparam int OPCODE_MSB = 0;
  localparam int OPCODE_LSB = 5;
  localparam logic [0:5] HALT_OP = 6'h3F;

  typedef struct packed {
    logic [0:IMEM_AW-1] pc;
    logic [0:INSTR_W-1] instr;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_buf.sv
// ifetch_buf: 2-entry synchronous prefetch FIFO with push, pop, flush and count.
// Ports:
//   clk, reset     : clock, asynchronous active-high reset (clears entries too)
//   flush_i        : drop all entries; wins over push/pop in the same cycle
//   push_i, wdata_i: write an entry at the write pointer
//   pop_i          : retire the head entry
//   head_o         : entry at the read pointer (holds last value when empty)
//   valid_o        : at least one entry present
//   count_o        : number of entries, 0..2
import ttwp_pkg::*;

module ifetch_buf (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  fetch_entry_t wdata_i,
  output fetch_entry_t head_o,
  output logic         valid_o,
  output logic [1:0]   count_o
);

  fetch_entry_t ent_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic [1:0]   count_d;

  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ent_q[0] <= '0;
      ent_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush_i) begin
      // Entry storage is left alone; with count at zero it is invisible.
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        ent_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  assign head_o  = ent_q[rd_ptr_q];
  assign valid_o = (count_q != 2'd0);
  assign count_o = count_q;

endmodule

// File: rtl/ifetch.sv
// ifetch: instruction fetch stage. Drives the instruction memory address from
// the PC register, captures the combinational read data into a 2-entry
// prefetch buffer and presents the head entry to decode over valid/ready.
// Branch redirects from execute flush the buffer and reload the PC.
// Optional feature macro: IFETCH_HALT_EN -- when defined, fetching a word whose
// opcode is HALT_OP stops fetch until redirect or reset; when undefined,
// halted is tied low and no opcode decode exists.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   imem_addr    : word address to instruction memory (the PC register)
//   imem_data    : instruction word read from imem_addr this cycle
//   redirect     : branch/jump taken; redirect_pc is the new PC
//   if_valid/if_ready : handshake to decode
//   if_instr/if_pc    : head entry instruction and address
//   halted       : fetch stopped on HALT
import ttwp_pkg::*;

module ifetch #(
  parameter int                 DEPTH    = 2,  // only 2 is supported
  parameter logic [0:IMEM_AW-1] RESET_PC = 8'h00
) (
  input  logic               clk,
  input  logic               reset,
  output logic [0:IMEM_AW-1] imem_addr,
  input  logic [0:INSTR_W-1] imem_data,
  input  logic               redirect,
  input  logic [0:IMEM_AW-1] redirect_pc,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [0:INSTR_W-1] if_instr,
  output logic [0:IMEM_AW-1] if_pc,
  output logic               halted
);

  logic [0:IMEM_AW-1] pc_q;
  logic [1:0]         count;
  logic               pop;
  logic               full;
  logic               fetch;
  fetch_entry_t       push_ent;
  fetch_entry_t       head_ent;

  assign pop  = if_valid & if_ready;
  assign full = (count == 2'(DEPTH));

`ifdef IFETCH_HALT_EN
  logic halted_q;
  logic is_halt;

  assign is_halt = (imem_data[OPCODE_MSB:OPCODE_LSB] == HALT_OP);
  assign fetch   = ~redirect & ~halted_q & (~full | pop);
  assign halted  = halted_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      halted_q <= 1'b0;
    end else if (redirect) begin
      halted_q <= 1'b0;
    end else if (fetch && is_halt) begin
      halted_q <= 1'b1;
    end
  end
`else
  assign fetch  = ~redirect & (~full | pop);
  assign halted = 1'b0;
`endif

  // PC: redirect wins; otherwise advance (mod 256) on every accepted fetch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else if (redirect) begin
      pc_q <= redirect_pc;
    end else if (fetch) begin
      pc_q <= pc_q + 8'd1;
    end
  end

  assign push_ent.pc    = pc_q;
  assign push_ent.instr = imem_data;

  // A pop coinciding with redirect is still a completed transfer to decode;
  // the flush simply takes priority inside the buffer.
  ifetch_buf u_buf (
    .clk     (clk),
    .reset   (reset),
    .flush_i (redirect),
    .push_i  (fetch),
    .pop_i   (pop),
    .wdata_i (push_ent),
    .head_o  (head_ent),
    .valid_o (if_valid),
    .count_o (count)
  );

  assign imem_addr = pc_q;
  assign if_instr  = head_ent.instr;
  assign if_pc     = head_ent.pc;

endmodule

// File: tb/tb_ifetch.sv
module tb_ifetch;

`ifdef IFETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [0:7]  imem_addr;
  logic [0:31] imem_data;
  logic        redirect;
  logic [0:7]  redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [0:31] if_instr;
  logic [0:7]  if_pc;
  logic        halted;

  logic [31:0] mem [256];

  typedef struct {
    logic [7:0]  pc;
    logic [31:0] instr;
  } ent_t;

  ent_t       q[$];
  logic [7:0] pc_m;
  bit         halted_m;
  int         n_tests = 0;
  int         n_fail  = 0;

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr];

  ifetch #(.DEPTH(2), .RESET_PC(8'h00)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .if_valid    (if_valid),
    .if_ready    (if_ready),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .halted      (halted)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("valid", 64'(if_valid), 64'(q.size() > 0));
    if (q.size() > 0) begin
      chk("if_pc", 64'(if_pc), 64'(q[0].pc));
      chk("if_instr", 64'(if_instr), 64'(q[0].instr));
    end
    chk("imem_addr", 64'(imem_addr), 64'(pc_m));
    chk("halted", 64'(halted), 64'(halted_m));
  endtask

  task automatic model_reset();
    q.delete();
    pc_m     = 8'h00;
    halted_m = 1'b0;
  endtask

  // One clock: decide pop/fetch from the pre-edge state, then apply the rules.
  task automatic step();
    bit   pop_m;
    bit   fetch_m;
    ent_t e;
    pop_m   = (q.size() > 0) && if_ready;
    fetch_m = !redirect && !halted_m && ((q.size() < 2) || pop_m);
    @(posedge clk);
    #1;
    if (redirect) begin
      q.delete();
      pc_m     = redirect_pc;
      halted_m = 1'b0;
    end else begin
      if (pop_m) e = q.pop_front();
      if (fetch_m) begin
        e.pc    = pc_m;
        e.instr = mem[pc_m];
        q.push_back(e);
        if (HALT_EN && e.instr[31:26] == 6'h3F) halted_m = 1'b1;
        pc_m = pc_m + 8'd1;
      end
    end
    check_model();
  endtask

  // Asserts reset between edges, checks outputs right away, releases after an edge.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    chk("rst_valid", 64'(if_valid), 64'd0);
    chk("rst_instr", 64'(if_instr), 64'd0);
    chk("rst_pc", 64'(if_pc), 64'd0);
    chk("rst_addr", 64'(imem_addr), 64'h00);
    chk("rst_halted", 64'(halted), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 8'h00;
    if_ready    = 1'b1;
    // Opcodes kept below HALT_OP so directed sequences are not cut short.
    for (int i = 0; i < 256; i++) mem[i] = $urandom & 32'h7FFF_FFFF;
    model_reset();

    // 1: streaming from reset, no bubbles
    mem[0] = 32'h0000_00A0; mem[1] = 32'h0000_00A1;
    mem[2] = 32'h0000_00A2; mem[3] = 32'h0000_00A3;
    do_reset();
    if_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t1_pc", 64'(if_pc), 64'(i));
      chk("t1_instr", 64'(if_instr), 64'(32'hA0 + i));
      chk("t1_valid", 64'(if_valid), 64'd1);
    end

    // 2: backpressure then drain
    do_reset();
    if_ready = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("t2_addr", 64'(imem_addr), 64'h02);
    chk("t2_head", 64'(if_pc), 64'h00);
    if_ready = 1'b1;
    for (int i = 1; i < 3; i++) begin
      step();
      chk("t2_pc", 64'(if_pc), 64'(i));
    end

    // 3: redirect while full with a pop
    chk("t3_pre_valid", 64'(if_valid), 64'd1);
    redirect = 1'b1; redirect_pc = 8'h40;
    step();
    redirect = 1'b0;
    chk("t3_bubble", 64'(if_valid), 64'd0);
    step();
    chk("t3_pc", 64'(if_pc), 64'h40);
    chk("t3_instr", 64'(if_instr), 64'(mem[8'h40]));

    // 4: PC wrap
    redirect = 1'b1; redirect_pc = 8'hFE;
    step();
    redirect = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t4_pc", 64'(if_pc), 64'((8'hFE + i) & 8'hFF));
    end

    // 5: asynchronous reset mid-stream with a full buffer
    if_ready = 1'b0;
    redirect = 1'b1; redirect_pc = 8'h35;
    step();
    redirect = 1'b0;
    step();
    step();
    chk("t5_pre_addr", 64'(imem_addr), 64'h37);
    chk("t5_pre_valid", 64'(if_valid), 64'd1);
    #2;
    do_reset();
    step();
    chk("t5_first_pc", 64'(if_pc), 64'h00);

    // 6: HALT opcode at address 5
    mem[5] = 32'hFC00_0000;
    do_reset();
    if_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("t6_halted", 64'(halted), 64'(HALT_EN));
    chk("t6_head5", 64'(if_pc), 64'h05);
    for (int i = 0; i < 3; i++) step();
    chk("t6_addr", 64'(imem_addr), HALT_EN ? 64'h06 : 64'h09);
    redirect = 1'b1; redirect_pc = 8'h10;
    step();
    redirect = 1'b0;
    chk("t6_clr", 64'(halted), 64'd0);
    step();
    chk("t6_resume", 64'(if_pc), 64'h10);

    // Random traffic, with a few HALT words sprinkled in
    for (int i = 0; i < 8; i++) mem[$urandom_range(0, 255)] = 32'hFC00_0000 | ($urandom & 32'h03FF_FFFF);
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 99) == 0) begin
        #2;
        do_reset();
      end
      if_ready    = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = 8'($urandom);
      step();
    end
    redirect = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
